// File: rtl/chnl_pkg.sv
// rtl/chnl_pkg.sv - shared widths and types for the channel receive slice
package chnl_pkg;

  localparam int CHNL_DW = 8;
  localparam int CNT_W   = 16;

  typedef logic [CHNL_DW-1:0] chnl_data_t;

endpackage

// File: rtl/chnl_sync_fifo.sv
// rtl/chnl_sync_fifo.sv - synchronous FIFO with a registered first-word-fall-through head
module chnl_sync_fifo #(
  parameter int  DEPTH = 32,
  parameter int  DW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   occ_after_rd;
  logic [AW:0]   count_nxt;

  always_comb begin
    rd_ptr_nxt   = rd_ptr + AW'(rd_en);
    occ_after_rd = count - (AW+1)'(rd_en);
    count_nxt    = occ_after_rd + (AW+1)'(wr_en);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // A write into an otherwise-empty FIFO becomes the head directly, since
  // mem[rd_ptr_nxt] still holds stale data during that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_en);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      if (wr_en && (occ_after_rd == '0)) begin
        rd_data <= wr_data;
      end else if (count_nxt != '0) begin
        rd_data <= mem[rd_ptr_nxt];
      end
    end
  end

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/chnl_rx_slave.sv
// rtl/chnl_rx_slave.sv - channel receive slave: handshake gating, margin and byte counter
module chnl_rx_slave
  import chnl_pkg::*;
#(
  parameter int  DEPTH = 32,
  parameter int  DW    = CHNL_DW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic [DW-1:0]    ch_data,
  input  logic             ch_valid,
  output logic             ch_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      margin,
  output logic [CNT_W-1:0] rx_cnt
);

  logic        wr_en;
  logic        rd_en;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic [AW:0] count_nxt;

  // ch_ready looks only at registered state, en and rst, never at ch_valid.
  assign ch_ready  = en & ~full & ~rst;
  assign out_valid = ~empty;
  assign wr_en     = ch_valid & ch_ready;
  assign rd_en     = out_valid & out_ready;
  assign count_nxt = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);

  chnl_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (ch_data),
    .rd_en   (rd_en),
    .rd_data (out_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // clr_cnt wins over the increment but still counts a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      margin <= (AW+1)'(DEPTH);
      rx_cnt <= '0;
    end else begin
      margin <= (AW+1)'(DEPTH) - count_nxt;
      if (clr_cnt) begin
        rx_cnt <= CNT_W'(wr_en);
      end else if (wr_en) begin
        rx_cnt <= rx_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_chnl_rx_slave.sv
// tb/tb_chnl_rx_slave.sv - self-checking bench for chnl_rx_slave against a queue model
module tb_chnl_rx_slave;
  import chnl_pkg::*;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst, en, clr_cnt, ch_valid, out_ready;
  chnl_data_t ch_data;
  logic       ch_ready, out_valid;
  chnl_data_t out_data;
  logic [5:0] margin;
  logic [15:0] rx_cnt;

  chnl_data_t  q_model[$];
  logic [15:0] cnt_model;
  bit          last_acc;
  int          n_cmp = 0;
  int          n_fail = 0;

  chnl_rx_slave dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr_cnt   (clr_cnt),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .margin    (margin),
    .rx_cnt    (rx_cnt)
  );

  always #5 clk = ~clk;

  property p_sender_hold;
    @(posedge clk) disable iff (rst)
      (ch_valid && !ch_ready) |=> (ch_valid && $stable(ch_data));
  endproperty
  a_sender_hold: assert property (p_sender_hold) else $error("sender hold rule broken by stimulus");

  // Advances one clock and applies the channel rules to the queue model.
  task automatic step();
    bit         acc, pop, r, clr;
    chnl_data_t d;
    acc = ch_valid && en && !rst && (q_model.size() < DEPTH);
    pop = out_ready && (q_model.size() != 0);
    d   = ch_data;
    r   = rst;
    clr = clr_cnt;
    @(posedge clk);
    if (r) begin
      q_model.delete();
      cnt_model = 16'h0;
      acc = 1'b0;
    end else begin
      if (pop) void'(q_model.pop_front());
      if (acc) q_model.push_back(d);
      if (clr) cnt_model = acc ? 16'd1 : 16'd0;
      else if (acc) cnt_model = cnt_model + 16'd1;
    end
    last_acc = acc;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0; ch_valid = 1'b0; ch_data = '0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ch_ready: got %b want 0", ch_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (margin !== 6'd32) begin n_fail++; $display("FAIL reset_margin: got %0d want 32", margin); end
    n_cmp++; if (rx_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_rx_cnt: got %0d want 0", rx_cnt); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    chnl_data_t exp_seq[3];
    exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33;
    en = 1'b1; out_ready = 1'b0; ch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ch_data = exp_seq[i];
      #1;
      n_cmp++; if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ch_ready[%0d]: got %b want 1", i, ch_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin n_fail++; $display("FAIL basic_head[%0d]: got v=%b d=%h want v=1 d=11", i, out_valid, out_data); end
    end
    ch_valid = 1'b0;
    n_cmp++; if (margin !== 6'd29) begin n_fail++; $display("FAIL basic_margin: got %0d want 29", margin); end
    n_cmp++; if (rx_cnt !== 16'd3) begin n_fail++; $display("FAIL basic_rx_cnt: got %0d want 3", rx_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_seq[i]) begin n_fail++; $display("FAIL basic_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_seq[i]); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0 || margin !== 6'd32) begin n_fail++; $display("FAIL basic_empty: got v=%b m=%0d want v=0 m=32", out_valid, margin); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    chnl_data_t b33;
    int guard;
    en = 1'b1; out_ready = 1'b0; ch_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      ch_data = chnl_data_t'($urandom);
      step();
    end
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ch_ready_full: got %b want 0", ch_ready); end
    n_cmp++; if (margin !== 6'd0) begin n_fail++; $display("FAIL fill_margin_full: got %0d want 0", margin); end
    b33 = chnl_data_t'($urandom);
    ch_data = b33;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (ch_ready !== 1'b1 || margin !== 6'd1) begin n_fail++; $display("FAIL fill_after_pop: got r=%b m=%0d want r=1 m=1", ch_ready, margin); end
    step();
    n_cmp++; if (margin !== 6'd0 || q_model[DEPTH-1] !== b33) begin n_fail++; $display("FAIL fill_byte33: got m=%0d want m=0", margin); end
    ch_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q_model.size() != 0 && guard < 2*DEPTH) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== q_model[0]) begin n_fail++; $display("FAIL fill_order[%0d]: got v=%b d=%h want v=1 d=%h", guard, out_valid, out_data, q_model[0]); end
      step();
      guard++;
    end
    n_cmp++; if (out_valid !== 1'b0 || margin !== 6'd32) begin n_fail++; $display("FAIL fill_drained: got v=%b m=%0d want v=0 m=32", out_valid, margin); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    chnl_data_t d;
    int bad = 0;
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    en = 1'b1; out_ready = 1'b1; ch_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = chnl_data_t'($urandom);
      ch_data = d;
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== d || margin !== 6'd31) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL stream[%0d]: got v=%b d=%h m=%0d want v=1 d=%h m=31", i, out_valid, out_data, margin, d);
      end
    end
    n_cmp++; if (rx_cnt !== 16'd100) begin n_fail++; $display("FAIL stream_rx_cnt: got %0d want 100", rx_cnt); end
    ch_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_enable();
    chnl_data_t held;
    logic [15:0] cnt_before;
    int guard;
    en = 1'b1; out_ready = 1'b0; ch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ch_data = chnl_data_t'($urandom);
      step();
    end
    held = chnl_data_t'($urandom);
    ch_data = held;
    en = 1'b0;
    cnt_before = cnt_model;
    #1;
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL en_drop_ready: got %b want 0", ch_ready); end
    step();
    n_cmp++; if (margin !== 6'd27 || rx_cnt !== cnt_before) begin n_fail++; $display("FAIL en_no_write: got m=%0d c=%0d want m=27 c=%0d", margin, rx_cnt, cnt_before); end
    out_ready = 1'b1;
    guard = 0;
    while (out_valid === 1'b1 && guard < 40) begin
      n_cmp++; if (out_data !== q_model[0]) begin n_fail++; $display("FAIL en_drain[%0d]: got %h want %h", guard, out_data, q_model[0]); end
      step();
      guard++;
    end
    n_cmp++; if (out_valid !== 1'b0 || margin !== 6'd32 || guard != 5) begin n_fail++; $display("FAIL en_drained: got v=%b m=%0d pops=%0d want v=0 m=32 pops=5", out_valid, margin, guard); end
    en = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== held || rx_cnt !== cnt_before + 16'd1) begin n_fail++; $display("FAIL en_resume: got v=%b d=%h c=%0d want v=1 d=%h c=%0d", out_valid, out_data, rx_cnt, held, cnt_before + 16'd1); end
    ch_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int bad = 0;
    ch_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!ch_valid || last_acc) begin
        ch_valid = ($urandom_range(0, 3) != 0);
        ch_data  = chnl_data_t'($urandom);
      end
      out_ready = (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      en        = ($urandom_range(0, 9) != 0);
      clr_cnt   = ($urandom_range(0, 49) == 0);
      #1;
      n_cmp++;
      if (ch_ready !== (en && q_model.size() < DEPTH)) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL rand_ready[%0d]: got %b want %b", i, ch_ready, en && q_model.size() < DEPTH);
      end
      step();
      n_cmp++;
      if (out_valid !== (q_model.size() != 0) || margin !== 6'(DEPTH - q_model.size()) || rx_cnt !== cnt_model
          || (q_model.size() != 0 && out_data !== q_model[0])) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL rand_state[%0d]: got v=%b m=%0d c=%0d want v=%b m=%0d c=%0d", i, out_valid, margin, rx_cnt,
                              q_model.size() != 0, DEPTH - q_model.size(), cnt_model);
      end
    end
    ch_valid = 1'b0; clr_cnt = 1'b0; en = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    out_ready = 1'b0;
  endtask

  task automatic test_rx_wrap();
    clr_cnt = 1'b1; ch_valid = 1'b0; step(); clr_cnt = 1'b0;
    en = 1'b1; out_ready = 1'b1; ch_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      ch_data = chnl_data_t'($urandom);
      step();
    end
    n_cmp++; if (rx_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffff", rx_cnt); end
    step();
    n_cmp++; if (rx_cnt !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h want 0000", rx_cnt); end
    step(); step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_cmp++; if (rx_cnt !== 16'd1) begin n_fail++; $display("FAIL clr_with_write: got %0d want 1", rx_cnt); end
    ch_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; out_ready = 1'b0; ch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ch_data = chnl_data_t'($urandom);
      step();
    end
    ch_valid = 1'b0;
    n_cmp++; if (margin !== 6'd22) begin n_fail++; $display("FAIL rstmid_pre_margin: got %0d want 22", margin); end
    rst = 1'b1;
    #1;
    n_cmp++; if (ch_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_reset: got %b want 0", ch_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0 || margin !== 6'd32 || rx_cnt !== 16'd0) begin n_fail++; $display("FAIL rstmid_state: got v=%b m=%0d c=%0d want v=0 m=32 c=0", out_valid, margin, rx_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (ch_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", ch_ready); end
  endtask

  initial begin
    cnt_model = 16'h0;
    last_acc  = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_stream();
    test_enable();
    test_random();
    test_rx_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
